pulse_cdc_arbiter: RTL and testbench

//   Shares one pulse_handshake CDC channel between NUM_REQ source-domain requesters.

---
 rtl/pulse_cdc_arb_pkg.sv | 25 ++
 rtl/pulse_cdc_arbiter_rr_arbiter.sv | 48 ++++
 rtl/pulse_cdc_arbiter.sv | 168 ++++++++++++++++
 tb/tb_pulse_cdc_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_cdc_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_cdc_arb_pkg
// Description : Shared FSM encodings and sizing helpers for pulse_cdc_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_cdc_arb_pkg;

    // Handshake FSM encodings
    localparam int         c_ST_W      = 2;
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_LAUNCH = 2'd1;
    localparam logic [1:0] c_ST_ARM    = 2'd2;
    localparam logic [1:0] c_ST_DRAIN  = 2'd3;

    // Width of a counter that must hold the value 0..timeout (at least 1 bit)
    function automatic int tmo_cnt_w(input int timeout);
        if (timeout < 1) begin
            return 1;
        end
        return $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_cdc_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Searches the request vector
//               starting at i_ptr and wrapping modulo NUM_REQ; returns the
//               first hit as both one-hot and index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_gnt_idx,
    output logic               o_any
);

    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_pos;
    logic            w_found;

    // Walk the requesters from the pointer, wrapping once, and keep the first hit
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_sum     = '0;
        w_pos     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, i_ptr} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (ID_W+1)'(NUM_REQ);
            end
            w_pos = w_sum[ID_W-1:0];
            if (!w_found && i_req[w_pos]) begin
                w_found      = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_gnt_idx    = w_pos;
            end
        end
    end

    assign o_any = |i_req;

endmodule
`default_nettype wire

// File: rtl/pulse_cdc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pulse_cdc_arbiter
// Description : Shares one pulse-handshake CDC channel between NUM_REQ
//               source-domain requesters. Events are latched as pending,
//               granted round-robin, and launched one at a time with chan_id
//               held stable for the whole channel handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_cdc_arbiter
    import pulse_cdc_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int RSP_TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NUM_REQ-1:0]         req_pulse,
    input  logic                       chan_busy,
    output logic                       chan_pulse,
    output logic [$clog2(NUM_REQ)-1:0] chan_id,
    output logic [NUM_REQ-1:0]         pend,
    output logic [NUM_REQ-1:0]         drop,
    input  logic [NUM_REQ-1:0]         drop_clr,
    output logic                       done_vld,
    output logic [$clog2(NUM_REQ)-1:0] done_id,
    output logic                       timeout_err,
    input  logic                       err_clr
);

    localparam int              ID_W      = $clog2(NUM_REQ);
    localparam int              CNT_W     = tmo_cnt_w(RSP_TIMEOUT);
    localparam logic [CNT_W-1:0] c_TMO_MAX = CNT_W'(RSP_TIMEOUT);
    localparam logic [ID_W-1:0]  c_LAST_ID = ID_W'(NUM_REQ - 1);
    localparam bit              c_TMO_EN  = (RSP_TIMEOUT != 0);

    logic [c_ST_W-1:0]  r_state;
    logic [NUM_REQ-1:0] r_pend;
    logic [NUM_REQ-1:0] r_drop;
    logic [NUM_REQ-1:0] r_gnt_oh;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_chan_id;
    logic [ID_W-1:0]    r_done_id;
    logic [CNT_W-1:0]   r_tmo_cnt;
    logic               r_chan_pulse;
    logic               r_done_vld;
    logic               r_timeout_err;

    logic [NUM_REQ-1:0] w_gnt_oh;
    logic [ID_W-1:0]    w_gnt_idx;
    logic               w_any;
    logic [NUM_REQ-1:0] w_launch_oh;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_expire;
    logic               w_tmo_set;
    logic [ID_W-1:0]    w_rr_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .i_req     (r_pend),
        .i_ptr     (r_rr_ptr),
        .o_gnt     (w_gnt_oh),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    // The launching requester is the one latched at grant time
    assign w_launch_oh = (r_state == c_ST_LAUNCH) ? r_gnt_oh : '0;
    assign w_rr_next   = (r_chan_id == c_LAST_ID) ? '0 : r_chan_id + ID_W'(1);

    // Counter saturates at the limit so it can never wrap back to zero
    assign w_cnt_inc = (r_tmo_cnt == c_TMO_MAX) ? r_tmo_cnt : r_tmo_cnt + CNT_W'(1);
    assign w_expire  = c_TMO_EN && (w_cnt_inc == c_TMO_MAX);

    // A timeout fires only when the awaited channel edge has not arrived
    assign w_tmo_set = w_expire &&
                       (((r_state == c_ST_ARM)   && !chan_busy) ||
                        ((r_state == c_ST_DRAIN) &&  chan_busy));

    // Pending and drop flags; a fresh event during its own launch re-arms pend
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
            r_drop <= '0;
        end else begin
            r_pend <= req_pulse | (r_pend & ~w_launch_oh);
            r_drop <= (req_pulse & r_pend & ~w_launch_oh) | (r_drop & ~drop_clr);
        end
    end

    // Sticky timeout error; a same-cycle timeout beats the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_tmo_set | (r_timeout_err & ~err_clr);
        end
    end

    // Handshake FSM with grant, rr pointer, timeout counter and output pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_gnt_oh     <= '0;
            r_rr_ptr     <= '0;
            r_chan_id    <= '0;
            r_done_id    <= '0;
            r_tmo_cnt    <= '0;
            r_chan_pulse <= 1'b0;
            r_done_vld   <= 1'b0;
        end else begin
            r_chan_pulse <= 1'b0;
            r_done_vld   <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (en && w_any && !chan_busy) begin
                        r_state      <= c_ST_LAUNCH;
                        r_chan_id    <= w_gnt_idx;
                        r_gnt_oh     <= w_gnt_oh;
                        r_chan_pulse <= 1'b1;
                    end
                end
                c_ST_LAUNCH: begin
                    r_rr_ptr  <= w_rr_next;
                    r_tmo_cnt <= '0;
                    r_state   <= c_ST_ARM;
                end
                c_ST_ARM: begin
                    if (chan_busy) begin
                        r_tmo_cnt <= '0;
                        r_state   <= c_ST_DRAIN;
                    end else if (w_expire) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_tmo_cnt <= w_cnt_inc;
                    end
                end
                c_ST_DRAIN: begin
                    if (!chan_busy) begin
                        r_done_vld <= 1'b1;
                        r_done_id  <= r_chan_id;
                        r_state    <= c_ST_IDLE;
                    end else if (w_expire) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_tmo_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign chan_pulse  = r_chan_pulse;
    assign chan_id     = r_chan_id;
    assign pend        = r_pend;
    assign drop        = r_drop;
    assign done_vld    = r_done_vld;
    assign done_id     = r_done_id;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_pulse_cdc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_cdc_arbiter
// Description : Self-checking bench for pulse_cdc_arbiter with a behavioural
//               channel and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_cdc_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int RSP_TIMEOUT = 8;
    localparam int ID_W        = $clog2(NUM_REQ);

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [NUM_REQ-1:0] req_pulse;
    logic               chan_busy = 1'b0;
    logic [NUM_REQ-1:0] drop_clr;
    logic               err_clr;
    logic               chan_pulse;
    logic [ID_W-1:0]    chan_id;
    logic [NUM_REQ-1:0] pend;
    logic [NUM_REQ-1:0] drop;
    logic               done_vld;
    logic [ID_W-1:0]    done_id;
    logic               timeout_err;

    pulse_cdc_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .RSP_TIMEOUT (RSP_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req_pulse   (req_pulse),
        .chan_busy   (chan_busy),
        .chan_pulse  (chan_pulse),
        .chan_id     (chan_id),
        .pend        (pend),
        .drop        (drop),
        .drop_clr    (drop_clr),
        .done_vld    (done_vld),
        .done_id     (done_id),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- channel model ----------------
    int busy_left   = 0;
    bit ch_respond  = 1'b1;
    bit noresp_rand = 1'b0;
    int forced_dur  = 0;
    int dur_max     = 6;

    always @(negedge clk) begin
        if (busy_left > 0) begin
            chan_busy = 1'b1;
            busy_left--;
        end else begin
            chan_busy = 1'b0;
        end
        if (chan_pulse === 1'b1 && ch_respond) begin
            if (!(noresp_rand && $urandom_range(0, 9) == 0)) begin
                busy_left = (forced_dur > 0) ? forced_dur : int'($urandom_range(1, dur_max));
            end
        end
    end

    // ---------------- reference model ----------------
    int                 cyc = 0;
    bit                 chk_on = 1'b0;
    bit [NUM_REQ-1:0]   m_pend, m_drop;
    bit                 m_err, m_pulse, m_done;
    int                 m_id, m_done_id, m_last, m_phase, m_age;

    always @(posedge clk) begin : model
        int lid, nid, j;
        bit can, tmo, fin, found, launching, dset;
        cyc++;
        if (rst) begin
            m_pend = '0; m_drop = '0; m_err = 1'b0; m_pulse = 1'b0; m_done = 1'b0;
            m_id = 0; m_done_id = 0; m_last = NUM_REQ - 1; m_phase = 0; m_age = 0;
            chk_on = 1'b1;
        end else begin
            lid = m_pulse ? m_id : -1;
            can = !m_pulse && (m_phase == 0) && en && (m_pend != 0) && !chan_busy;
            nid = m_last;
            found = 1'b0;
            for (int k = 1; k <= NUM_REQ; k++) begin
                j = (m_last + k) % NUM_REQ;
                if (!found && m_pend[j]) begin
                    found = 1'b1;
                    nid = j;
                end
            end
            tmo = 1'b0;
            fin = 1'b0;
            if (m_pulse) begin
                m_phase = 1; m_age = 0;
            end else if (m_phase == 1) begin
                if (chan_busy) begin
                    m_phase = 2; m_age = 0;
                end else if (RSP_TIMEOUT != 0 && m_age + 1 == RSP_TIMEOUT) begin
                    tmo = 1'b1; m_phase = 0;
                end else begin
                    m_age++;
                end
            end else if (m_phase == 2) begin
                if (!chan_busy) begin
                    fin = 1'b1; m_phase = 0;
                end else if (RSP_TIMEOUT != 0 && m_age + 1 == RSP_TIMEOUT) begin
                    tmo = 1'b1; m_phase = 0;
                end else begin
                    m_age++;
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                launching = (lid == i);
                dset = req_pulse[i] && m_pend[i] && !launching;
                m_drop[i] = dset || (m_drop[i] && !drop_clr[i]);
                m_pend[i] = req_pulse[i] || (m_pend[i] && !launching);
            end
            m_err  = tmo || (m_err && !err_clr);
            m_done = fin;
            if (fin) m_done_id = m_id;
            m_pulse = can;
            if (can) begin
                m_id = nid;
                m_last = nid;
            end
        end
    end

    // ---------------- per-cycle checker / monitor ----------------
    int grants[$];
    int n_done  = 0;
    int t_pulse = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            check("chan_pulse", 32'(chan_pulse), 32'(m_pulse));
            check("done_vld", 32'(done_vld), 32'(m_done));
            check("pend", 32'(pend), 32'(m_pend));
            check("drop", 32'(drop), 32'(m_drop));
            check("timeout_err", 32'(timeout_err), 32'(m_err));
            if (m_pulse) check("chan_id", 32'(chan_id), 32'(m_id));
            if (m_done) check("done_id", 32'(done_id), 32'(m_done_id));
            if (chan_pulse === 1'b1) begin
                grants.push_back(int'(chan_id));
                t_pulse = cyc;
            end
            if (done_vld === 1'b1) n_done++;
        end
    end

    function automatic int get_grant(input int i);
        if (i < grants.size()) return grants[i];
        return -1;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(m_phase == 0 && !m_pulse && m_pend == 0 && !chan_busy && busy_left == 0) && n < budget);
        step();
        check("wait_idle", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_pulse(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (chan_pulse !== 1'b1 && n < budget);
        check("wait_pulse", 32'(chan_pulse), 32'd1);
    endtask

    int t_req;

    initial begin
        rst = 1'b1; en = 1'b0; req_pulse = '0; drop_clr = '0; err_clr = 1'b0;
        repeat (3) step();
        check("rst_chan_id", 32'(chan_id), 32'd0);
        check("rst_done_id", 32'(done_id), 32'd0);
        check("rst_chan_pulse", 32'(chan_pulse), 32'd0);
        rst = 1'b0; en = 1'b1;
        step();

        // 1: single event, latency and completion
        grants.delete(); n_done = 0;
        t_req = cyc; req_pulse = 4'b0001; step(); req_pulse = '0;
        wait_idle(100);
        check("t1_latency", 32'(t_pulse - t_req), 32'd2);
        check("t1_ngrant", 32'(grants.size()), 32'd1);
        check("t1_id", 32'(get_grant(0)), 32'd0);
        check("t1_done", 32'(n_done), 32'd1);
        check("t1_pend", 32'(pend), 32'd0);

        // 2: all four at once from a fresh pointer
        rst = 1'b1; step(); rst = 1'b0; step();
        grants.delete(); n_done = 0;
        req_pulse = 4'b1111; step(); req_pulse = '0;
        wait_idle(200);
        check("t2_ngrant", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("t2_order", 32'(get_grant(i)), 32'(i));
        check("t2_drop", 32'(drop), 32'd0);
        check("t2_done", 32'(n_done), 32'd4);

        // 3: pointer continues past 3 and wraps
        grants.delete();
        req_pulse = 4'b0110; step(); req_pulse = '0;
        wait_idle(200);
        check("t3_ngrant", 32'(grants.size()), 32'd2);
        check("t3_first", 32'(get_grant(0)), 32'd1);
        check("t3_second", 32'(get_grant(1)), 32'd2);

        // 4: repeated event while pending is dropped
        en = 1'b0;
        req_pulse = 4'b0100; step(); req_pulse = '0; step();
        req_pulse = 4'b0100; step(); req_pulse = '0; step();
        check("t4_drop", 32'(drop), 32'h4);
        grants.delete(); en = 1'b1;
        wait_idle(100);
        check("t4_ngrant", 32'(grants.size()), 32'd1);
        check("t4_id", 32'(get_grant(0)), 32'd2);
        drop_clr = 4'b0100; step(); drop_clr = '0; step();
        check("t4_drop_clr", 32'(drop), 32'd0);

        // 5: new event during its own launch keeps it pending
        grants.delete();
        req_pulse = 4'b0010; step(); req_pulse = '0;
        wait_pulse(20);
        req_pulse = 4'b0010; step(); req_pulse = '0;
        check("t5_pend1", 32'(pend[1]), 32'd1);
        wait_idle(100);
        check("t5_ngrant", 32'(grants.size()), 32'd2);
        check("t5_second", 32'(get_grant(1)), 32'd1);

        // 6: channel never answers -> timeout after RSP_TIMEOUT ARM cycles
        grants.delete(); n_done = 0; ch_respond = 1'b0;
        req_pulse = 4'b0001; step(); req_pulse = '0;
        wait_pulse(20);
        repeat (RSP_TIMEOUT) step();
        check("t6_err_before", 32'(timeout_err), 32'd0);
        step();
        check("t6_err_after", 32'(timeout_err), 32'd1);
        err_clr = 1'b1; step(); err_clr = 1'b0; step();
        check("t6_err_clr", 32'(timeout_err), 32'd0);
        ch_respond = 1'b1;
        req_pulse = 4'b1000; step(); req_pulse = '0;
        wait_idle(100);
        check("t6_ngrant", 32'(grants.size()), 32'd2);
        check("t6_next", 32'(get_grant(1)), 32'd3);
        check("t6_done", 32'(n_done), 32'd1);

        // reset while draining
        forced_dur = 6;
        req_pulse = 4'b0010; step(); req_pulse = '0;
        wait_pulse(20);
        req_pulse = 4'b0001; step(); req_pulse = '0;
        step(); step();
        check("t7_pre_id", 32'(chan_id), 32'd1);
        check("t7_pre_pend", 32'(pend), 32'd1);
        rst = 1'b1; step();
        check("t7_chan_pulse", 32'(chan_pulse), 32'd0);
        check("t7_chan_id", 32'(chan_id), 32'd0);
        check("t7_pend", 32'(pend), 32'd0);
        check("t7_drop", 32'(drop), 32'd0);
        check("t7_done_vld", 32'(done_vld), 32'd0);
        check("t7_done_id", 32'(done_id), 32'd0);
        check("t7_timeout_err", 32'(timeout_err), 32'd0);
        rst = 1'b0; forced_dur = 0;
        wait_idle(100);

        // randomized traffic, including long and missing channel responses
        dur_max = 12; noresp_rand = 1'b1;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_pulse[i] = ($urandom_range(0, 7) == 0);
                drop_clr[i]  = ($urandom_range(0, 9) == 0);
            end
            en      = ($urandom_range(0, 7) != 0);
            err_clr = ($urandom_range(0, 7) == 0);
            step();
        end
        req_pulse = '0; drop_clr = '0; err_clr = 1'b0; en = 1'b1;
        wait_idle(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
